// File: rtl/cache_pkg.sv
// Shared types for the cache set controller: FSM states, way index, geometry helpers.
// Way index is sized generously so any legal NUM_WAYS fits; modules compare, never slice with it.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_ALLOC,
    ST_RESP
  } cache_ctrl_state_t;

  localparam int WAY_IDX_W = 8;
  typedef logic [WAY_IDX_W-1:0] way_idx_t;

  function automatic int offset_width(input int block_size);
    return $clog2(block_size);
  endfunction

  function automatic int tag_width(input int address_width, input int block_size);
    return address_width - $clog2(block_size);
  endfunction

endpackage

// File: rtl/cache_victim_select.sv
// Victim choice for a miss: lowest invalid way, else lowest expired way, else oldest (ties low).
// Purely combinational, zero latency, no flow control.
module cache_victim_select
  import cache_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int COUNTER_WIDTH = 8
) (
  input  logic [NUM_WAYS-1:0]               wayValid,
  input  logic [NUM_WAYS-1:0]               wayExpired,
  input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] wayAge,
  output way_idx_t                          victim
);

  logic                     inv_found;
  logic                     exp_found;
  way_idx_t                 inv_idx;
  way_idx_t                 exp_idx;
  way_idx_t                 max_idx;
  logic [COUNTER_WIDTH-1:0] max_age;

  always_comb begin
    inv_found = 1'b0;
    exp_found = 1'b0;
    inv_idx   = '0;
    exp_idx   = '0;
    max_idx   = '0;
    max_age   = wayAge[0 +: COUNTER_WIDTH];
    // Scan downwards so the lowest matching index is the last one written.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!wayValid[i]) begin
        inv_found = 1'b1;
        inv_idx   = way_idx_t'(i);
      end
      if (wayExpired[i]) begin
        exp_found = 1'b1;
        exp_idx   = way_idx_t'(i);
      end
    end
    for (int i = 1; i < NUM_WAYS; i++) begin
      if (wayAge[i*COUNTER_WIDTH +: COUNTER_WIDTH] > max_age) begin
        max_age = wayAge[i*COUNTER_WIDTH +: COUNTER_WIDTH];
        max_idx = way_idx_t'(i);
      end
    end
    if (inv_found)      victim = inv_idx;
    else if (exp_found) victim = exp_idx;
    else                victim = max_idx;
  end

endmodule

// File: rtl/cache_set_controller.sv
// Single cache set sequencer: lookup, dirty writeback, fill, allocate, respond. Perf counters under CACHE_PERF_CNT_EN.
// Latency: hit responds 2 cycles after accept; miss adds memory wait plus one ALLOC cycle.
// Backpressure: reqReady only in IDLE; memory requests held stable until memReqReady.
module cache_set_controller
  import cache_pkg::*;
#(
  parameter int NUM_WAYS      = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int DATA_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   reqValid,
  output logic                                                   reqReady,
  input  logic                                                   reqWrite,
  input  logic [ADDRESS_WIDTH-1:0]                               reqAddr,
  input  logic [DATA_WIDTH-1:0]                                  reqData,
  output logic                                                   respValid,
  output logic [DATA_WIDTH-1:0]                                  respData,
  output logic                                                   respHit,
  input  logic [NUM_WAYS*tag_width(ADDRESS_WIDTH, BLOCK_SIZE)-1:0] wayTag,
  input  logic [NUM_WAYS-1:0]                                    wayValid,
  input  logic [NUM_WAYS-1:0]                                    wayDirty,
  input  logic [NUM_WAYS-1:0]                                    wayExpired,
  input  logic [NUM_WAYS*COUNTER_WIDTH-1:0]                      wayAge,
  input  logic [NUM_WAYS*DATA_WIDTH-1:0]                         wayDataOut,
  output logic [NUM_WAYS-1:0]                                    wayWEn,
  output logic [NUM_WAYS-1:0]                                    wayAllocate,
  output logic [NUM_WAYS-1:0]                                    wayAccessed,
  output logic [COUNTER_WIDTH-1:0]                               accessedWayAge,
  output logic [ADDRESS_WIDTH-1:0]                               wayAddress,
  output logic [DATA_WIDTH-1:0]                                  wayDataIn,
  output logic                                                   memReqValid,
  input  logic                                                   memReqReady,
  output logic                                                   memReqWrite,
  output logic [ADDRESS_WIDTH-1:0]                               memAddr,
  output logic [DATA_WIDTH-1:0]                                  memWData,
  input  logic                                                   memRespValid,
  input  logic [DATA_WIDTH-1:0]                                  memRData,
  output logic [31:0]                                            hitCount,
  output logic [31:0]                                            missCount,
  output logic [31:0]                                            evictCount
);

  localparam int OFFSET_WIDTH = offset_width(BLOCK_SIZE);
  localparam int TAG_WIDTH    = tag_width(ADDRESS_WIDTH, BLOCK_SIZE);

  cache_ctrl_state_t        state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     write_q, write_d;
  logic [DATA_WIDTH-1:0]    load_q, load_d;
  logic                     hit_q, hit_d;
  way_idx_t                 victim_q, victim_d;

  way_idx_t                 victim_sel;
  logic [TAG_WIDTH-1:0]     req_tag;
  logic                     hit_found;
  way_idx_t                 hit_idx;
  logic [NUM_WAYS-1:0]      hit_oh;
  logic [NUM_WAYS-1:0]      vq_oh;
  logic [DATA_WIDTH-1:0]    hit_data;
  logic [COUNTER_WIDTH-1:0] hit_age;
  logic                     sel_valid;
  logic                     sel_dirty;
  logic [TAG_WIDTH-1:0]     vq_tag;
  logic [DATA_WIDTH-1:0]    vq_data;
  logic [COUNTER_WIDTH-1:0] vq_age;

  cache_victim_select #(
    .NUM_WAYS      (NUM_WAYS),
    .COUNTER_WIDTH (COUNTER_WIDTH)
  ) u_victim_select (
    .wayValid   (wayValid),
    .wayExpired (wayExpired),
    .wayAge     (wayAge),
    .victim     (victim_sel)
  );

  assign req_tag = addr_q[ADDRESS_WIDTH-1 -: TAG_WIDTH];

  // Tag match plus per-way muxes for the hit way, the fresh victim and the latched victim.
  always_comb begin
    hit_found = 1'b0;
    hit_idx   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (wayValid[i] && wayTag[i*TAG_WIDTH +: TAG_WIDTH] == req_tag) begin
        hit_found = 1'b1;
        hit_idx   = way_idx_t'(i);
      end
    end
    hit_oh    = '0;
    vq_oh     = '0;
    hit_data  = '0;
    hit_age   = '0;
    sel_valid = 1'b0;
    sel_dirty = 1'b0;
    vq_tag    = '0;
    vq_data   = '0;
    vq_age    = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (way_idx_t'(i) == hit_idx) begin
        hit_oh[i] = 1'b1;
        hit_data  = wayDataOut[i*DATA_WIDTH +: DATA_WIDTH];
        hit_age   = wayAge[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
      if (way_idx_t'(i) == victim_sel) begin
        sel_valid = wayValid[i];
        sel_dirty = wayDirty[i];
      end
      if (way_idx_t'(i) == victim_q) begin
        vq_oh[i] = 1'b1;
        vq_tag   = wayTag[i*TAG_WIDTH +: TAG_WIDTH];
        vq_data  = wayDataOut[i*DATA_WIDTH +: DATA_WIDTH];
        vq_age   = wayAge[i*COUNTER_WIDTH +: COUNTER_WIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    data_d         = data_q;
    write_d        = write_q;
    load_d         = load_q;
    hit_d          = hit_q;
    victim_d       = victim_q;
    reqReady       = (state_q == ST_IDLE);
    respValid      = 1'b0;
    respData       = '0;
    respHit        = 1'b0;
    wayWEn         = '0;
    wayAllocate    = '0;
    wayAccessed    = '0;
    accessedWayAge = '0;
    wayAddress     = addr_q;
    wayDataIn      = '0;
    memReqValid    = 1'b0;
    memReqWrite    = 1'b0;
    memAddr        = '0;
    memWData       = '0;
    case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          addr_d  = reqAddr;
          data_d  = reqData;
          write_d = reqWrite;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (hit_found) begin
          hit_d          = 1'b1;
          wayAccessed    = hit_oh;
          accessedWayAge = hit_age;
          if (write_q) begin
            wayWEn    = hit_oh;
            wayDataIn = data_q;
          end else begin
            load_d = hit_data;
          end
          state_d = ST_RESP;
        end else begin
          hit_d    = 1'b0;
          victim_d = victim_sel;
          if (sel_valid && sel_dirty) state_d = ST_WRITEBACK;
          else if (!write_q)          state_d = ST_FILL_REQ;
          else                        state_d = ST_ALLOC;
        end
      end
      ST_WRITEBACK: begin
        memReqValid = 1'b1;
        memReqWrite = 1'b1;
        memAddr     = {vq_tag, {OFFSET_WIDTH{1'b0}}};
        memWData    = vq_data;
        if (memReqReady) state_d = write_q ? ST_ALLOC : ST_FILL_REQ;
      end
      ST_FILL_REQ: begin
        memReqValid = 1'b1;
        memAddr     = {req_tag, {OFFSET_WIDTH{1'b0}}};
        if (memReqReady) state_d = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (memRespValid) begin
          load_d  = memRData;
          state_d = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        wayAllocate    = vq_oh;
        wayWEn         = vq_oh;
        wayAccessed    = vq_oh;
        wayDataIn      = write_q ? data_q : load_q;
        accessedWayAge = vq_age;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        respValid = 1'b1;
        respHit   = hit_q;
        respData  = write_q ? '0 : load_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      load_q   <= '0;
      hit_q    <= 1'b0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      write_q  <= write_d;
      load_q   <= load_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] evict_cnt_q, evict_cnt_d;

  // Counters saturate rather than wrap.
  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    evict_cnt_d = evict_cnt_q;
    if (state_q == ST_LOOKUP && hit_found && hit_cnt_q != '1)   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (state_q == ST_LOOKUP && !hit_found && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_q == ST_WRITEBACK && memReqReady && evict_cnt_q != '1)
      evict_cnt_d = evict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      evict_cnt_q <= '0;
    end else begin
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      evict_cnt_q <= evict_cnt_d;
    end
  end

  assign hitCount   = hit_cnt_q;
  assign missCount  = miss_cnt_q;
  assign evictCount = evict_cnt_q;
`else
  assign hitCount   = '0;
  assign missCount  = '0;
  assign evictCount = '0;
`endif

endmodule

// File: tb/tb_cache_set_controller.sv
// Directed bench for cache_set_controller: hit, miss, writeback, expired victim, mid-op reset.
module tb_cache_set_controller;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reqValid, reqReady, reqWrite;
  logic [31:0]       reqAddr, reqData;
  logic              respValid, respHit;
  logic [31:0]       respData;
  logic [3:0][26:0]  tag_a;
  logic [3:0]        wayValid, wayDirty, wayExpired;
  logic [3:0][7:0]   age_a;
  logic [3:0][31:0]  data_a;
  logic [3:0]        wayWEn, wayAllocate, wayAccessed;
  logic [7:0]        accessedWayAge;
  logic [31:0]       wayAddress, wayDataIn;
  logic              memReqValid, memReqReady, memReqWrite;
  logic [31:0]       memAddr, memWData;
  logic              memRespValid;
  logic [31:0]       memRData;
  logic [31:0]       hitCount, missCount, evictCount;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cache_set_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .reqValid       (reqValid),
    .reqReady       (reqReady),
    .reqWrite       (reqWrite),
    .reqAddr        (reqAddr),
    .reqData        (reqData),
    .respValid      (respValid),
    .respData       (respData),
    .respHit        (respHit),
    .wayTag         (tag_a),
    .wayValid       (wayValid),
    .wayDirty       (wayDirty),
    .wayExpired     (wayExpired),
    .wayAge         (age_a),
    .wayDataOut     (data_a),
    .wayWEn         (wayWEn),
    .wayAllocate    (wayAllocate),
    .wayAccessed    (wayAccessed),
    .accessedWayAge (accessedWayAge),
    .wayAddress     (wayAddress),
    .wayDataIn      (wayDataIn),
    .memReqValid    (memReqValid),
    .memReqReady    (memReqReady),
    .memReqWrite    (memReqWrite),
    .memAddr        (memAddr),
    .memWData       (memWData),
    .memRespValid   (memRespValid),
    .memRData       (memRData),
    .hitCount       (hitCount),
    .missCount      (missCount),
    .evictCount     (evictCount)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] dat);
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddr  = addr;
    reqData  = dat;
    tick();
    reqValid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqData = '0;
    tag_a = '0; wayValid = '0; wayDirty = '0; wayExpired = '0; age_a = '0; data_a = '0;
    memReqReady = 1'b0; memRespValid = 1'b0; memRData = '0;
    tick(); tick();
    chk("rst_reqReady", reqReady, 1);
    chk("rst_respValid", respValid, 0);
    chk("rst_memReqValid", memReqValid, 0);
    chk("rst_wayWEn", wayWEn, 0);
    chk("rst_wayAddress", wayAddress, 0);
    rst_n = 1'b1;

    // Load hit in way2, tag 2 == addr 0x40
    tag_a    = {27'h7, 27'h2, 27'h10, 27'h9};
    wayValid = 4'b0110;
    age_a    = {8'h40, 8'h30, 8'h20, 8'h10};
    data_a   = {32'h33, 32'hDEADBEEF, 32'h11, 32'h00};
    tick();
    request(1'b0, 32'h40, 32'h0);
    chk("hit_ld_reqReady", reqReady, 0);
    chk("hit_ld_accessed", wayAccessed, 4'b0100);
    chk("hit_ld_wen", wayWEn, 4'b0000);
    chk("hit_ld_age", accessedWayAge, 8'h30);
    chk("hit_ld_resp_early", respValid, 0);
    tick();
    chk("hit_ld_respValid", respValid, 1);
    chk("hit_ld_respHit", respHit, 1);
    chk("hit_ld_respData", respData, 32'hDEADBEEF);
    tick();
    chk("hit_ld_idle", {reqReady, respValid}, 2'b10);

    // Store hit in way1, tag 0x10 == addr 0x200
    request(1'b1, 32'h200, 32'h1234);
    chk("hit_st_wen", wayWEn, 4'b0010);
    chk("hit_st_datain", wayDataIn, 32'h1234);
    chk("hit_st_accessed", wayAccessed, 4'b0010);
    tick();
    chk("hit_st_resp", {respValid, respHit}, 2'b11);
    chk("hit_st_respData", respData, 0);
    tick();

    // Load miss, ways 0/1 invalid -> victim way0, fill from block 0x1220
    wayValid = 4'b1100;
    tag_a    = {27'h7, 27'h2, 27'h10, 27'h9};
    request(1'b0, 32'h1234, 32'h0);
    chk("miss_ld_lookup_mem", memReqValid, 0);
    chk("miss_ld_lookup_acc", wayAccessed, 0);
    tick();
    chk("fill_req_vld", {memReqValid, memReqWrite}, 2'b10);
    chk("fill_req_addr", memAddr, 32'h1220);
    tick(); tick();
    chk("fill_req_hold", {memReqValid, memAddr}, {1'b1, 32'h1220});
    memReqReady = 1'b1; memRespValid = 1'b1; memRData = 32'hBAD;
    tick();
    memReqReady = 1'b0; memRespValid = 1'b0;
    chk("fill_wait_memvld", memReqValid, 0);
    chk("fill_wait_early_data", wayAllocate, 0);
    tick();
    chk("fill_wait_still", wayAllocate, 0);
    memRespValid = 1'b1; memRData = 32'hA5A5;
    tick();
    memRespValid = 1'b0;
    chk("alloc_ld_alloc", wayAllocate, 4'b0001);
    chk("alloc_ld_wen_acc", {wayWEn, wayAccessed}, 8'b0001_0001);
    chk("alloc_ld_datain", wayDataIn, 32'hA5A5);
    chk("alloc_ld_age", accessedWayAge, 8'h10);
    tick();
    chk("miss_ld_resp", {respValid, respHit}, 2'b10);
    chk("miss_ld_respData", respData, 32'hA5A5);
    tick();

    // Load miss, all valid, way3 dirty and oldest -> writeback then fill
    tag_a    = {27'h55, 27'h3, 27'h2, 27'h1};
    wayValid = 4'b1111;
    wayDirty = 4'b1000;
    age_a    = {8'hF0, 8'h30, 8'h20, 8'h10};
    data_a   = {32'hCAFE0003, 32'h2, 32'h1, 32'h0};
    request(1'b0, 32'h2000, 32'h0);
    tick();
    chk("wb_vld_wr", {memReqValid, memReqWrite}, 2'b11);
    chk("wb_addr", memAddr, 32'hAA0);
    chk("wb_wdata", memWData, 32'hCAFE0003);
    tick();
    chk("wb_hold", {memReqValid, memReqWrite, memAddr, memWData}, {2'b11, 32'hAA0, 32'hCAFE0003});
    memReqReady = 1'b1;
    tick();
    chk("wb_fill_req", {memReqValid, memReqWrite, memAddr}, {2'b10, 32'h2000});
    tick();
    memReqReady = 1'b0;
    memRespValid = 1'b1; memRData = 32'h77;
    tick();
    memRespValid = 1'b0;
    chk("wb_alloc", wayAllocate, 4'b1000);
    chk("wb_alloc_age", accessedWayAge, 8'hF0);
    tick();
    chk("wb_resp", {respValid, respHit, respData}, {2'b10, 32'h77});
    tick();

    // Store miss, way1 expired and clean -> direct allocate, no memory traffic
    wayDirty   = 4'b0000;
    wayExpired = 4'b0010;
    request(1'b1, 32'h3000, 32'h9999);
    chk("st_miss_mem_lookup", memReqValid, 0);
    tick();
    chk("st_miss_mem_alloc", memReqValid, 0);
    chk("st_miss_alloc", wayAllocate, 4'b0010);
    chk("st_miss_datain", wayDataIn, 32'h9999);
    chk("st_miss_age", accessedWayAge, 8'h20);
    tick();
    chk("st_miss_resp", {respValid, respHit, respData}, {2'b10, 32'h0});
    tick();
    wayExpired = 4'b0000;

`ifdef CACHE_PERF_CNT_EN
    chk("cnt_hit", hitCount, 2);
    chk("cnt_miss", missCount, 3);
    chk("cnt_evict", evictCount, 1);
`endif

    // Reset while waiting on fill data abandons the transaction
    wayValid = 4'b1110;
    request(1'b0, 32'h4000, 32'h0);
    tick();
    chk("rst_mid_fill_req", memReqValid, 1);
    memReqReady = 1'b1;
    tick();
    memReqReady = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst_mid_reqReady", reqReady, 1);
    chk("rst_mid_memReqValid", memReqValid, 0);
    chk("rst_mid_wayAddress", wayAddress, 0);
    chk("rst_mid_counters", {hitCount, missCount, evictCount}, 0);
    rst_n = 1'b1;
    memRespValid = 1'b1; memRData = 32'h5555;
    tick();
    memRespValid = 1'b0;
    chk("rst_mid_no_alloc", {wayAllocate, respValid, reqReady}, {4'b0, 1'b0, 1'b1});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_set_controller.md
Name: cache_set_controller

Overview:
Sequences one cache set of NUM_WAYS ways: accepts a CPU load/store, does the tag lookup across all ways, and selects a victim on a miss. On a miss it writes back a dirty victim, fills from memory, then allocates the line and responds. It drives each way's wEn/dataIn/allocate/accessed/accessedWayAge controls and sits between the CPU request port, the way array and the next-level memory port.

Parameters:
NUM_WAYS, 4, ways in the set (power of two, >=2)
COUNTER_WIDTH, 8, width of per-way age counters
DATA_WIDTH, 32, line payload width (one word per line)
BLOCK_SIZE, 32, bytes per block; OFFSET_WIDTH = $clog2(BLOCK_SIZE)
ADDRESS_WIDTH, 32, address width; TAG_WIDTH = ADDRESS_WIDTH-OFFSET_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
reqValid  in  1  CPU request valid
reqReady  out  1  controller can accept a request
reqWrite  in  1  1=store, 0=load
reqAddr  in  ADDRESS_WIDTH  request address
reqData  in  DATA_WIDTH  store data
respValid  out  1  one-cycle response pulse
respData  out  DATA_WIDTH  load data; 0 for stores
respHit  out  1  request hit, qualified by respValid
wayTag  in  NUM_WAYS*TAG_WIDTH  per-way tag, way i at [i*TAG_WIDTH +: TAG_WIDTH]
wayValid  in  NUM_WAYS  per-way valid
wayDirty  in  NUM_WAYS  per-way dirty
wayExpired  in  NUM_WAYS  per-way expired flag
wayAge  in  NUM_WAYS*COUNTER_WIDTH  per-way myAge
wayDataOut  in  NUM_WAYS*DATA_WIDTH  per-way read data
wayWEn  out  NUM_WAYS  one-hot write enable
wayAllocate  out  NUM_WAYS  one-hot allocate
wayAccessed  out  NUM_WAYS  one-hot access pulse
accessedWayAge  out  COUNTER_WIDTH  age of accessed way, broadcast
wayAddress  out  ADDRESS_WIDTH  latched request address, broadcast
wayDataIn  out  DATA_WIDTH  write data, broadcast
memReqValid  out  1  memory request valid
memReqReady  in  1  memory accepts request
memReqWrite  out  1  1=writeback, 0=fill read
memAddr  out  ADDRESS_WIDTH  block address, offset bits 0
memWData  out  DATA_WIDTH  writeback data
memRespValid  in  1  fill data valid
memRData  in  DATA_WIDTH  fill data
hitCount, missCount, evictCount  out  32 each  perf counters, see Optional Feature

Behaviour:
- Reset: state IDLE; every output 0 except reqReady=1; latched request and victim cleared. Reset mid-operation abandons any memory transaction; memReqValid drops at the next edge.
- States: IDLE, LOOKUP, WRITEBACK, FILL_REQ, FILL_WAIT, ALLOC, RESP.
- IDLE: reqReady=1. On reqValid, latch addr/data/write and go to LOOKUP. reqReady=0 in all other states.
- LOOKUP (1 cycle): hit[i] = wayValid[i] && wayTag[i]==addr tag. More than one hit is illegal; the lowest index wins.
  - Load hit: capture wayDataOut[hit].
  - Store hit: wayWEn[hit]=1 and wayDataIn=reqData for this cycle.
  - Any hit: wayAccessed[hit]=1, accessedWayAge=wayAge[hit], next state RESP with respHit=1.
- Victim on miss, first match wins:
  - lowest-index invalid way;
  - otherwise lowest-index wayExpired;
  - otherwise the way with maximum wayAge, ties to the lowest index.
  - The victim index is latched.
- Miss transitions:
  - victim valid && dirty: WRITEBACK.
  - otherwise, load: FILL_REQ.
  - otherwise, store: ALLOC (no fill, full-word write).
- WRITEBACK: memReqValid=1, memReqWrite=1, memAddr={victim tag, 0}, memWData=victim data. Hold all of these stable until memReqReady, then go to FILL_REQ (load) or ALLOC (store).
- FILL_REQ: memReqValid=1, memReqWrite=0, memAddr={addr tag, 0}. Hold until memReqReady, then FILL_WAIT.
- FILL_WAIT: wait for memRespValid and capture memRData. If memRespValid arrives in the same cycle as memReqReady, it is ignored; fill data is accepted only in FILL_WAIT.
- ALLOC (1 cycle): wayAllocate[v]=wayWEn[v]=wayAccessed[v]=1, wayDataIn = fill data (load) or reqData (store), accessedWayAge=wayAge[v]. Next state RESP with respHit=0.
- RESP (1 cycle): respValid=1; respData = load data or 0. Return to IDLE; reqReady rises the following cycle.
- Latency: hit = request accept + 2 cycles to respValid. Miss = 2 + memory wait cycles + 1 (ALLOC).
- One-hot outputs are all-zero outside the cycles listed above.

Optional Feature:
CACHE_PERF_CNT_EN
- Defined:
  - hitCount increments on each hit in LOOKUP.
  - missCount increments on each miss in LOOKUP.
  - evictCount increments on WRITEBACK completion.
  - All three are 32-bit, saturate at all-ones, and reset to 0.
- Undefined: ports remain but are tied to 0; no counter flops.

Decomposition:
- Package cache_pkg: state enum cache_ctrl_state_t, OFFSET_WIDTH/TAG_WIDTH derivation functions, and a way-index type.
- One sub-module, cache_victim_select: purely combinational, takes wayValid/wayExpired/wayAge and returns the victim index.

Test Plan:
- Reset then load, addr 0x40, with way2 valid and tag matching, data 0xDEADBEEF -> respValid 2 cycles after accept, respHit=1, respData=0xDEADBEEF, wayAccessed=0100.
- Store hit way1, reqData 0x1234 -> wayWEn=0010 with wayDataIn=0x1234 in the LOOKUP cycle, respHit=1, respData=0.
- Load miss with ways 0 and 1 invalid -> victim way0, FILL_REQ memAddr=block addr; memReqReady after 3 cycles, memRData=0xA5A5 -> ALLOC wayAllocate=0001, respData=0xA5A5, respHit=0.
- Load miss, all valid, way3 dirty with max age 0xF0, no expired -> WRITEBACK memReqWrite=1 with way3 tag/data held until ready, then fill, then allocate way3.
- All valid, way1 expired, way3 max age -> victim way1. Store miss, way1 clean -> no memory traffic, ALLOC with reqData.
- rst_n low during FILL_WAIT -> next edge IDLE, memReqValid=0, reqReady=1. With CACHE_PERF_CNT_EN defined, counters read 0.
